// File: rtl/ucie_ctl_sb_pkg.sv
// Shared types, header layout and header builder for the sideband message transmitter.
// Optional parity generation is controlled by the UCIE_SB_PARITY_EN macro.
package ucie_ctl_sb_pkg;

    localparam int REQ_W = 37;

    localparam logic [4:0] SB_DEC_NULL   = 5'd0;
    localparam logic [4:0] SB_DEC_ADVCAP = 5'd1;

    localparam int HDR_CP_BIT  = 31;
    localparam int HDR_DP_BIT  = 30;
    localparam int HDR_SRC_LSB = 27;
    localparam int HDR_DST_LSB = 24;
    localparam int HDR_DEC_LSB = 16;
    localparam int HDR_PLD_BIT = 0;

    typedef enum logic [1:0] {
        SB_TX_IDLE = 2'd0,
        SB_TX_HDR  = 2'd1,
        SB_TX_PLD  = 2'd2
    } sb_tx_state_e;

    // dp_raw is the payload parity; it only lands in the header when a payload follows.
    function automatic logic [31:0] sb_build_header(input logic [2:0] srcid,
                                                    input logic [2:0] dstid,
                                                    input logic [4:0] decode,
                                                    input logic       dp_raw);
        logic [31:0] hdr;
        logic        has_pld;
        hdr     = '0;
        has_pld = (decode == SB_DEC_ADVCAP);
        hdr[HDR_SRC_LSB +: 3] = srcid;
        hdr[HDR_DST_LSB +: 3] = dstid;
        hdr[HDR_DEC_LSB +: 5] = decode;
        hdr[HDR_PLD_BIT]      = has_pld;
        hdr[HDR_DP_BIT]       = has_pld & dp_raw;
`ifdef UCIE_SB_PARITY_EN
        hdr[HDR_CP_BIT] = ^hdr[30:0];
`else
        hdr[HDR_CP_BIT] = 1'b0;
`endif
        return hdr;
    endfunction

endpackage

// File: rtl/ucie_ctl_sb_msg_tx_if.sv
// Request and beat link bundle between the control FSM, this transmitter and the SB PHY.
interface ucie_ctl_sb_msg_tx_if;

    logic        i_sb_lp_valid;
    logic [4:0]  i_sb_lp_decode;
    logic [31:0] i_sb_lp_adv_cap_val;
    logic        o_sb_busy_flag;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [31:0] o_tx_data;
    logic        o_tx_last;
    logic        o_tx_drop;

    modport master (
        output i_sb_lp_valid, i_sb_lp_decode, i_sb_lp_adv_cap_val, i_tx_ready,
        input  o_sb_busy_flag, o_tx_valid, o_tx_data, o_tx_last, o_tx_drop
    );

    modport slave (
        input  i_sb_lp_valid, i_sb_lp_decode, i_sb_lp_adv_cap_val, i_tx_ready,
        output o_sb_busy_flag, o_tx_valid, o_tx_data, o_tx_last, o_tx_drop
    );

endinterface

// File: rtl/ucie_ctl_sb_req_fifo.sv
// Synchronous request FIFO with occupancy count; reset flushes pointers, storage is left as is.
module ucie_ctl_sb_req_fifo #(
    parameter  int WIDTH = 37,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/ucie_ctl_sb_msg_tx.sv
// Buffers lp message requests and serialises them into 32-bit sideband beats (header, optional payload).
// Define UCIE_SB_PARITY_EN to generate cp/dp header parity bits.
module ucie_ctl_sb_msg_tx
    import ucie_ctl_sb_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [2:0] SRCID      = 3'd1,
    parameter logic [2:0] DSTID      = 3'd5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ucie_ctl_sb_msg_tx_if.slave  sb
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    sb_tx_state_e     state;
    sb_tx_state_e     state_nxt;
    logic [CW-1:0]    count;
    logic [REQ_W-1:0] head;
    logic [4:0]       head_dec;
    logic [31:0]      head_cap;
    logic             has_pld;
    logic             dp_raw;
    logic             busy;
    logic             push;
    logic             pop;
    logic             drop;
    logic             tx_valid;
    logic [31:0]      tx_data;
    logic             tx_last;

    assign busy = i_rst || (count == CW'(FIFO_DEPTH));
    assign push = sb.i_sb_lp_valid && !busy && (sb.i_sb_lp_decode != SB_DEC_NULL);

    ucie_ctl_sb_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (pop),
        .wdata ({sb.i_sb_lp_decode, sb.i_sb_lp_adv_cap_val}),
        .rdata (head),
        .count (count)
    );

    assign head_dec = head[36:32];
    assign head_cap = head[31:0];
    assign has_pld  = (head_dec == SB_DEC_ADVCAP);

`ifdef UCIE_SB_PARITY_EN
    assign dp_raw = ^head_cap;
`else
    assign dp_raw = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= SB_TX_IDLE;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            drop  <= sb.i_sb_lp_valid && (busy || (sb.i_sb_lp_decode == SB_DEC_NULL));
        end
    end

    // A push in the popping cycle keeps the FIFO non-empty, so the next header follows immediately.
    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_last   = 1'b0;
        pop       = 1'b0;
        case (state)
            SB_TX_IDLE: begin
                if (count != '0) state_nxt = SB_TX_HDR;
            end
            SB_TX_HDR: begin
                tx_valid = 1'b1;
                tx_data  = sb_build_header(SRCID, DSTID, head_dec, dp_raw);
                tx_last  = !has_pld;
                if (sb.i_tx_ready) begin
                    if (has_pld) begin
                        state_nxt = SB_TX_PLD;
                    end else begin
                        pop       = 1'b1;
                        state_nxt = ((count > CW'(1)) || push) ? SB_TX_HDR : SB_TX_IDLE;
                    end
                end
            end
            SB_TX_PLD: begin
                tx_valid = 1'b1;
                tx_data  = head_cap;
                tx_last  = 1'b1;
                if (sb.i_tx_ready) begin
                    pop       = 1'b1;
                    state_nxt = ((count > CW'(1)) || push) ? SB_TX_HDR : SB_TX_IDLE;
                end
            end
            default: state_nxt = SB_TX_IDLE;
        endcase
    end

    assign sb.o_sb_busy_flag = busy;
    assign sb.o_tx_valid     = tx_valid;
    assign sb.o_tx_data      = tx_data;
    assign sb.o_tx_last      = tx_last;
    assign sb.o_tx_drop      = drop;

endmodule
